// File: rtl/shift_add_mult_16.sv
// Sequential 16x16 unsigned shift-and-add multiplier.
// One partial product is accumulated per RUN cycle through a 32-bit
// carry-lookahead adder. Every operation takes 16 RUN cycles, even when the
// multiplier runs out of set bits early. A single DONE cycle then reports the
// result.

// 32-bit carry-lookahead adder built from eight 4-bit lookahead groups.
// A second lookahead level chains the group carries.
module CLA_32bit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout,
   output logic        Pout,
   output logic        Gout
);

   logic [31:0] p;
   logic [31:0] g;
   logic [31:0] c;
   logic [7:0]  gp;
   logic [7:0]  gg;
   logic [8:0]  gc;
   logic        gAll;

   // Bit propagate/generate, group lookahead terms, then per-bit carries and sum
   always_comb begin
      p    = a ^ b;
      g    = a & b;
      gp   = '0;
      gg   = '0;
      gc   = '0;
      c    = '0;
      gAll = 1'b0;
      for (int k = 0; k < 8; k++) begin
         gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
         gg[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      end
      gc[0] = cin;
      for (int k = 0; k < 8; k++) begin
         gc[k+1] = gg[k] | (gp[k] & gc[k]);
         gAll    = gg[k] | (gp[k] & gAll);
      end
      for (int k = 0; k < 8; k++) begin
         c[4*k]   = gc[k];
         c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
      end
      sum  = p ^ c;
      cout = gc[8];
      Pout = &gp;
      Gout = gAll;
   end

endmodule

// Multiplier controller and datapath
module shift_add_mult_16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] product
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] mcand;
   logic [15:0] mplr;
   logic [31:0] acc;
   logic [3:0]  count;
   logic [31:0] addSum;
   logic        carry_unused;
   logic        pout_unused;
   logic        gout_unused;

   // Partial products never exceed 32 bits, so the carry out is never needed
   CLA_32bit u_cla (
      .a    (acc),
      .b    (mcand),
      .cin  (1'b0),
      .sum  (addSum),
      .cout (carry_unused),
      .Pout (pout_unused),
      .Gout (gout_unused)
   );

   // Accept in IDLE, add-and-shift for exactly 16 RUN cycles, pulse DONE once
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         mcand <= '0;
         mplr  <= '0;
         acc   <= '0;
         count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand <= {16'b0, a};
                  mplr  <= b;
                  acc   <= '0;
                  count <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               if (mplr[0]) begin
                  acc <= addSum;
               end
               mcand <= mcand << 1;
               mplr  <= mplr >> 1;
               count <= count + 4'd1;
               if (count == 4'd15) begin
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Status flags decode the registered state only
   always_comb begin
      busy    = (state == RUN);
      done    = (state == DONE);
      product = acc;
   end

endmodule
